mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates the single SRAM controller port between the instruction-fetch stage (read-only) and the memory stage (read/write) of the ARM pipeline. Requests are level-held; the block latches the winning request, drives the SRAM controller handshake, returns read data with a one-cycle done pulse, and guards against a hung controller with a timeout. It sits between the pipeline stages and the SRAM controller, running entirely in the core `clk` domain.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, maximum cycles in ACCESS without `sram_ready` (1..65535)

- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch read request, held until `if_done`
- if_addr  in  ADDR_W  fetch address
- if_done  out  1  one-cycle completion pulse to fetch
- if_rdata  out  DATA_W  fetch read data, valid when `if_done`=1, held until next fetch completion
- mem_req  in  1  memory-stage request, held until `mem_done`
- mem_we  in  1  1 = write, 0 = read
- mem_addr  in  ADDR_W  memory-stage address
- mem_wdata  in  DATA_W  write data
- mem_done  out  1  one-cycle completion pulse to memory stage
- mem_rdata  out  DATA_W  memory-stage read data, valid when `mem_done`=1, held until next mem completion
- sram_req  out  1  request to SRAM controller, held until `sram_ready`
- sram_we  out  1  latched write enable
- sram_addr  out  ADDR_W  latched address
- sram_wdata  out  DATA_W  latched write data
- sram_ready  in  1  one-cycle completion from SRAM controller
- sram_rdata  in  DATA_W  read data, valid with `sram_ready`
- busy  out  1  1 whenever state ≠ IDLE
- timeout_err  out  1  sticky; set on any timeout, cleared only by reset

## Operation
- FSM states: IDLE, ACCESS, RELEASE. Reset state IDLE.
- IDLE: if neither request is asserted, stay. Otherwise pick an owner (arbitration below), latch owner, `sram_we` (0 for fetch, `mem_we` for mem), `sram_addr`, and `sram_wdata` (0 for fetch), clear the timeout counter, and go to ACCESS.
- ACCESS: `sram_req`=1.
  - On `sram_ready`=1: capture `sram_rdata` into the owner's rdata register (reads only; mem writes leave `mem_rdata` unchanged), pulse the owner's done next cycle, go to RELEASE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 with no `sram_ready`: set `timeout_err`, load owner rdata with 0, pulse owner done, go to RELEASE.
- RELEASE: exactly one cycle with the owner's done=1 and `sram_req`=0. Requests are ignored. Then go to IDLE. Requesters drop req on the edge that samples done=1, so no duplicate grant occurs.
- Arbitration when both requests are asserted in IDLE: fixed priority, mem wins (older instruction), unless round-robin is compiled in (see Configuration). A lone request always wins.
- Arbiter ignores changes to owner address and data after latching.
- `sram_ready` in IDLE or RELEASE is ignored.
- Counter width is $clog2(TIMEOUT+1) and saturates; it does not wrap.
- Reset values: all outputs 0. This covers `sram_req`, `sram_we`, `sram_addr`, `sram_wdata`, both done, both rdata, `busy`, and `timeout_err`. Internal last_owner = fetch.
- Reset asserted mid-ACCESS: `sram_req` drops immediately (asynchronous), FSM returns to IDLE, and no done pulse is issued.

## Timing
- Cycle 0: req sampled high in IDLE.
- Cycle 1: ACCESS, `sram_req`=1.
- Minimum latency, with `sram_ready` high in cycle 1: done=1 in cycle 2, IDLE in cycle 3, next grant issued in cycle 3 with `sram_req` in cycle 4.
- General case, `sram_ready` in cycle k: done in cycle k+1, IDLE in cycle k+2.
- Timeout case, request accepted in cycle 0: done in cycle TIMEOUT+1.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - last_owner updates at each grant.
  - On a simultaneous request, the requester that is not last_owner wins.
  - First contention after reset therefore goes to mem; the next goes to fetch.
- ARB_ROUND_ROBIN_EN undefined: fixed mem-over-fetch priority; last_owner logic is absent.

## Test plan
- Lone fetch, `if_addr`=0x40, controller returns 0xE3A01005 two cycles after `sram_req` → `sram_we`=0, `sram_addr`=0x40, `if_done` pulses once with `if_rdata`=0xE3A01005, `mem_done` stays 0.
- Mem write, addr 0x400, wdata 0xDEADBEEF → `sram_we`=1, `sram_wdata`=0xDEADBEEF held until `sram_ready`, `mem_done` pulse, `mem_rdata` unchanged.
- Both requests held continuously with 1-cycle controller, fixed mode → mem is granted every time and fetch starves. Round-robin mode → grants alternate mem, fetch, mem, fetch.
- Controller never asserts ready with TIMEOUT=8 → `sram_req` high for 8 cycles, then `timeout_err`=1 (sticky), owner done pulses with rdata=0, and the next request is served normally.
- `sram_ready` pulsed during IDLE and RELEASE → no done pulse and no state change.
- Reset (low) asserted two cycles into ACCESS → `sram_req`, `busy`, and both done go to 0 immediately. After release, a held request is re-granted from IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Purpose : shares the single SRAM controller port between instruction fetch (read-only)
//           and the memory stage (read/write), with a hung-controller timeout.
// Latency : grant 1 cycle after req seen in IDLE; done 1 cycle after sram_ready; back in IDLE 1 cycle later.
// Backpressure: requests are level-held until their done pulse; one access in flight at a time,
//           and the loser of arbitration simply waits in IDLE with its request held.
//
// Ports:
//   clk, rst (async active-low)
//   if_req/if_addr -> if_done/if_rdata                       fetch side
//   mem_req/mem_we/mem_addr/mem_wdata -> mem_done/mem_rdata   memory-stage side
//   sram_req/sram_we/sram_addr/sram_wdata, sram_ready/sram_rdata   controller handshake
//   busy (state != IDLE), timeout_err (sticky until reset)
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration on contention;
//   otherwise the memory stage always wins (it holds the older instruction).
// Every output is a flop; there is no combinational input-to-output path.

module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_done,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              sram_req,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic              sram_ready,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              busy,
  output logic              timeout_err
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t state, state_d;

  // owner: 1 = memory stage, 0 = fetch
  logic              owner, owner_d;
  logic              grant_mem;
  logic [CNT_W-1:0]  cnt, cnt_d;

  logic              sram_req_d, sram_we_d;
  logic [ADDR_W-1:0] sram_addr_d;
  logic [DATA_W-1:0] sram_wdata_d;
  logic              if_done_d, mem_done_d;
  logic [DATA_W-1:0] if_rdata_d, mem_rdata_d;
  logic              busy_d, timeout_err_d;

`ifdef ARB_ROUND_ROBIN_EN
  // Who was granted most recently; 0 = fetch, so the first contention goes to mem.
  logic              last_owner, last_owner_d;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d       = state;
    owner_d       = owner;
    grant_mem     = 1'b0;
    cnt_d         = cnt;
    sram_req_d    = sram_req;
    sram_we_d     = sram_we;
    sram_addr_d   = sram_addr;
    sram_wdata_d  = sram_wdata;
    if_done_d     = 1'b0;
    mem_done_d    = 1'b0;
    if_rdata_d    = if_rdata;
    mem_rdata_d   = mem_rdata;
    timeout_err_d = timeout_err;
`ifdef ARB_ROUND_ROBIN_EN
    last_owner_d  = last_owner;
`endif

    case (state)
      IDLE: begin
        if (if_req || mem_req) begin
`ifdef ARB_ROUND_ROBIN_EN
          // On contention the requester that did not win last time gets the port.
          grant_mem    = mem_req && (!if_req || !last_owner);
          last_owner_d = grant_mem;
`else
          grant_mem    = mem_req;
`endif
          owner_d      = grant_mem;
          sram_we_d    = grant_mem & mem_we;
          sram_addr_d  = grant_mem ? mem_addr : if_addr;
          sram_wdata_d = grant_mem ? mem_wdata : '0;
          sram_req_d   = 1'b1;
          cnt_d        = '0;
          state_d      = ACCESS;
        end
      end

      ACCESS: begin
        if (sram_ready) begin
          // A ready in the last allowed cycle still counts as a normal completion.
          if (owner) begin
            if (!sram_we) mem_rdata_d = sram_rdata;
            mem_done_d = 1'b1;
          end else begin
            if_rdata_d = sram_rdata;
            if_done_d  = 1'b1;
          end
          sram_req_d = 1'b0;
          state_d    = RELEASE;
        end else if (cnt == CNT_LAST) begin
          // Controller hung: complete the access with zero data and flag it.
          timeout_err_d = 1'b1;
          if (owner) begin
            mem_rdata_d = '0;
            mem_done_d  = 1'b1;
          end else begin
            if_rdata_d = '0;
            if_done_d  = 1'b1;
          end
          sram_req_d = 1'b0;
          state_d    = RELEASE;
        end else if (cnt != CNT_MAX) begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      RELEASE: begin
        // Done is visible this cycle; requesters drop req on this edge.
        state_d = IDLE;
      end

      default: begin
        state_d    = IDLE;
        sram_req_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner       <= 1'b0;
      cnt         <= '0;
      sram_req    <= 1'b0;
      sram_we     <= 1'b0;
      sram_addr   <= '0;
      sram_wdata  <= '0;
      if_done     <= 1'b0;
      mem_done    <= 1'b0;
      if_rdata    <= '0;
      mem_rdata   <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      owner       <= owner_d;
      cnt         <= cnt_d;
      sram_req    <= sram_req_d;
      sram_we     <= sram_we_d;
      sram_addr   <= sram_addr_d;
      sram_wdata  <= sram_wdata_d;
      if_done     <= if_done_d;
      mem_done    <= mem_done_d;
      if_rdata    <= if_rdata_d;
      mem_rdata   <= mem_rdata_d;
      busy        <= busy_d;
      timeout_err <= timeout_err_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_owner <= 1'b0;
    end else begin
      last_owner <= last_owner_d;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose : self-checking bench for mem_port_arbiter (directed cases plus randomized transactions).
// Latency : checks grant, done and IDLE return at exact cycle offsets.
// Backpressure: requesters hold req until done and drop it on the done cycle.

module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_done;
  logic [DW-1:0] if_rdata;
  logic          mem_req = 1'b0;
  logic          mem_we = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic [DW-1:0] mem_wdata = '0;
  logic          mem_done;
  logic [DW-1:0] mem_rdata;
  logic          sram_req;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic          sram_ready = 1'b0;
  logic [DW-1:0] sram_rdata = '0;
  logic          busy;
  logic          timeout_err;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  bit            model_last_mem = 1'b0;
  logic [DW-1:0] exp_if_rdata   = '0;
  logic [DW-1:0] exp_mem_rdata  = '0;
  bit            exp_terr       = 1'b0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .sram_req(sram_req), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_ready(sram_ready), .sram_rdata(sram_rdata),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arbitration rule: a lone request wins; on contention mem wins (fixed)
  // or whoever was not granted last (round robin).
  function automatic bit pick_mem(input bit ir, input bit mr);
    if (!ir) return 1'b1;
    if (!mr) return 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    return !model_last_mem;
`else
    return 1'b1;
`endif
  endfunction

  // One complete transaction starting from an IDLE cycle; ready arrives dly cycles after sram_req rises.
  task automatic run_txn(input bit ir, input bit mr, input bit we,
                         input logic [AW-1:0] ia, input logic [AW-1:0] ma,
                         input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                         input int dly, input bit rel_ready);
    bit            gm;
    bit            ewe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd;
    gm  = pick_mem(ir, mr);
    model_last_mem = gm;
    ewe = gm & we;
    ea  = gm ? ma : ia;
    ewd = gm ? wd : '0;
    if_req = ir; mem_req = mr; mem_we = we; if_addr = ia; mem_addr = ma; mem_wdata = wd;
    tick();
    vectors++;
    if (sram_req !== 1'b1 || busy !== 1'b1) begin
      miscompares++; $display("FAIL grant_req: sram_req=%b busy=%b, expected 1 1", sram_req, busy);
    end
    vectors++;
    if ({sram_we, sram_addr, sram_wdata} !== {ewe, ea, ewd}) begin
      miscompares++;
      $display("FAIL grant_latch: we=%b addr=%h wdata=%h, expected we=%b addr=%h wdata=%h",
               sram_we, sram_addr, sram_wdata, ewe, ea, ewd);
    end
    // Latched values must not follow the inputs any more.
    if_addr = $urandom; mem_addr = $urandom; mem_wdata = $urandom; mem_we = 1'($urandom);
    for (int i = 0; i < dly; i++) begin
      tick();
      vectors++;
      if ({sram_req, sram_we, sram_addr, sram_wdata} !== {1'b1, ewe, ea, ewd}) begin
        miscompares++;
        $display("FAIL access_hold: req=%b we=%b addr=%h wdata=%h, expected 1 %b %h %h",
                 sram_req, sram_we, sram_addr, sram_wdata, ewe, ea, ewd);
      end
    end
    sram_ready = 1'b1; sram_rdata = rd;
    tick();
    sram_ready = rel_ready; sram_rdata = $urandom;
    if (gm) begin
      if (!ewe) exp_mem_rdata = rd;
    end else begin
      exp_if_rdata = rd;
    end
    vectors++;
    if ({if_done, mem_done, sram_req, busy} !== {!gm, gm, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL release: if_done=%b mem_done=%b sram_req=%b busy=%b, expected %b %b 0 1",
               if_done, mem_done, sram_req, busy, !gm, gm);
    end
    vectors++;
    if (if_rdata !== exp_if_rdata || mem_rdata !== exp_mem_rdata) begin
      miscompares++;
      $display("FAIL rdata: if_rdata=%h mem_rdata=%h, expected %h %h",
               if_rdata, mem_rdata, exp_if_rdata, exp_mem_rdata);
    end
    if_req = 1'b0; mem_req = 1'b0;
    tick();
    sram_ready = 1'b0;
    vectors++;
    if ({if_done, mem_done, busy, sram_req, timeout_err} !== {4'b0000, exp_terr}) begin
      miscompares++;
      $display("FAIL idle_return: if_done=%b mem_done=%b busy=%b sram_req=%b terr=%b, expected 0 0 0 0 %b",
               if_done, mem_done, busy, sram_req, timeout_err, exp_terr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    vectors++;
    if ({sram_req, sram_we, sram_addr, sram_wdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_sram: req=%b we=%b addr=%h wdata=%h, expected all 0", sram_req, sram_we, sram_addr, sram_wdata);
    end
    vectors++;
    if ({if_done, mem_done, if_rdata, mem_rdata, busy, timeout_err} !== '0) begin
      miscompares++;
      $display("FAIL reset_outs: if_done=%b mem_done=%b if_rdata=%h mem_rdata=%h busy=%b terr=%b, expected all 0",
               if_done, mem_done, if_rdata, mem_rdata, busy, timeout_err);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_lone_fetch();
    run_txn(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 32'hE3A01005, 2, 1'b0);
  endtask

  task automatic test_mem_write();
    run_txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h400, 32'hDEADBEEF, 32'h12345678, 1, 1'b0);
    // Mem read afterwards, with ready also pulsed in RELEASE (must be ignored)
    run_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h404, 32'hAAAA5555, 32'h0BADF00D, 0, 1'b1);
  endtask

  task automatic test_idle_ready();
    for (int i = 0; i < 3; i++) begin
      sram_ready = 1'b1; sram_rdata = $urandom;
      tick();
      vectors++;
      if ({busy, sram_req, if_done, mem_done} !== 4'b0000 ||
          if_rdata !== exp_if_rdata || mem_rdata !== exp_mem_rdata) begin
        miscompares++;
        $display("FAIL idle_ready: busy=%b req=%b if_done=%b mem_done=%b if_rdata=%h mem_rdata=%h, expected 0 0 0 0 %h %h",
                 busy, sram_req, if_done, mem_done, if_rdata, mem_rdata, exp_if_rdata, exp_mem_rdata);
      end
    end
    sram_ready = 1'b0;
  endtask

  // Both requesters held, controller always ready.
  task automatic test_contention();
    bit            gm;
    logic [DW-1:0] rd;
    if_req = 1'b1; mem_req = 1'b1; mem_we = 1'b0; if_addr = 32'h100; mem_addr = 32'h800;
    sram_ready = 1'b1;
    for (int g = 0; g < 6; g++) begin
      gm = pick_mem(1'b1, 1'b1);
      model_last_mem = gm;
      tick();
      rd = $urandom; sram_rdata = rd;
      vectors++;
      if (sram_req !== 1'b1 || sram_addr !== (gm ? 32'h800 : 32'h100)) begin
        miscompares++;
        $display("FAIL contention_grant[%0d]: req=%b addr=%h, expected 1 %h", g, sram_req, sram_addr, gm ? 32'h800 : 32'h100);
      end
      tick();
      if (gm) exp_mem_rdata = rd; else exp_if_rdata = rd;
      vectors++;
      if ({if_done, mem_done} !== {!gm, gm} || if_rdata !== exp_if_rdata || mem_rdata !== exp_mem_rdata) begin
        miscompares++;
        $display("FAIL contention_done[%0d]: if_done=%b mem_done=%b if_rdata=%h mem_rdata=%h, expected %b %b %h %h",
                 g, if_done, mem_done, if_rdata, mem_rdata, !gm, gm, exp_if_rdata, exp_mem_rdata);
      end
      if (g == 5) begin if_req = 1'b0; mem_req = 1'b0; end
      tick();
      vectors++;
      if (busy !== 1'b0) begin
        miscompares++; $display("FAIL contention_idle[%0d]: busy=%b, expected 0", g, busy);
      end
    end
    sram_ready = 1'b0;
  endtask

  task automatic test_random();
    int sel;
    for (int n = 0; n < 30; n++) begin
      sel = $urandom_range(1, 3);
      run_txn(sel[0], sel[1], 1'($urandom), $urandom, $urandom, $urandom, $urandom,
              $urandom_range(0, 5), 1'($urandom));
    end
  endtask

  // Ready in the final allowed ACCESS cycle completes normally.
  task automatic test_ready_boundary();
    run_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h2000, 32'h0, 32'hCAFEF00D, TO - 1, 1'b0);
  endtask

  task automatic test_timeout();
    int hi;
    if_req = 1'b1; if_addr = 32'h44;
    model_last_mem = 1'b0;
    hi = 0;
    for (int c = 1; c <= TO; c++) begin
      tick();
      if (sram_req === 1'b1) hi++;
    end
    vectors++;
    if (hi != TO) begin
      miscompares++; $display("FAIL timeout_req_cycles: sram_req high %0d cycles, expected %0d", hi, TO);
    end
    tick();
    exp_if_rdata = '0; exp_terr = 1'b1;
    vectors++;
    if ({if_done, mem_done, sram_req, timeout_err} !== 4'b1001 || if_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL timeout_done: if_done=%b mem_done=%b req=%b terr=%b if_rdata=%h, expected 1 0 0 1 0",
               if_done, mem_done, sram_req, timeout_err, if_rdata);
    end
    if_req = 1'b0;
    tick();
    run_txn(1'b1, 1'b1, 1'b0, 32'h48, 32'h900, 32'h0, 32'h5A5A5A5A, 1, 1'b0);
  endtask

  task automatic test_reset_mid_access();
    bit got;
    if_req = 1'b1; if_addr = 32'h80;
    tick(); tick();
    #1 rst = 1'b0;
    #1;
    exp_terr = 1'b0; exp_if_rdata = '0; exp_mem_rdata = '0; model_last_mem = 1'b0;
    vectors++;
    if ({sram_req, busy, if_done, mem_done, timeout_err} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_mid: req=%b busy=%b if_done=%b mem_done=%b terr=%b, expected all 0",
               sram_req, busy, if_done, mem_done, timeout_err);
    end
    @(negedge clk);
    rst = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 5 && !got; c++) begin
      tick();
      if (sram_req === 1'b1) got = 1'b1;
    end
    vectors++;
    if (!got || sram_addr !== 32'h80) begin
      miscompares++; $display("FAIL regrant: got=%b addr=%h, expected 1 00000080", got, sram_addr);
    end
    sram_ready = 1'b1; sram_rdata = 32'h600DCAFE;
    tick();
    sram_ready = 1'b0;
    exp_if_rdata = 32'h600DCAFE;
    vectors++;
    if (if_done !== 1'b1 || if_rdata !== exp_if_rdata || timeout_err !== 1'b0) begin
      miscompares++;
      $display("FAIL regrant_done: if_done=%b if_rdata=%h terr=%b, expected 1 %h 0", if_done, if_rdata, timeout_err, exp_if_rdata);
    end
    if_req = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lone_fetch();
    test_mem_write();
    test_idle_ready();
    test_contention();
    test_random();
    test_ready_boundary();
    test_timeout();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
